// File: rtl/w_buf_pkg.sv
// Shared weight-buffer definitions: default depth, FSM state encoding and the
// address wrap helper used by the read (and future write) controllers.
package w_buf_pkg;

    localparam int W_BUF_DEPTH = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRIME  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_PRIME  = ST_PRIME,
        S_STREAM = ST_STREAM
    } rd_state_e;

    // Next row address; wraps at depth-1 so non-power-of-2 depths work.
    function automatic int unsigned wrap(input int unsigned a, input int unsigned depth);
        return (a == depth - 32'd1) ? 32'd0 : a + 32'd1;
    endfunction

endpackage

// File: rtl/w_buf_rd_ctrl_if.sv
// Job control, w_buf read port and row-stream handshake of the weight-buffer
// read controller; master is the controller side, slave the environment side.
interface w_buf_rd_ctrl_if #(
    parameter int DEPTH      = w_buf_pkg::W_BUF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CNT_WIDTH-1:0]  num_rows;
    logic                  busy;
    logic                  done;
    logic                  buf_en;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic                  w_valid;
    logic                  w_ready;
    logic [CNT_WIDTH-1:0]  w_row;

    modport master (
        input  start, abort, base_addr, num_rows, w_ready,
        output busy, done, buf_en, buf_addr, w_valid, w_row
    );

    modport slave (
        output start, abort, base_addr, num_rows, w_ready,
        input  busy, done, buf_en, buf_addr, w_valid, w_row
    );
endinterface

// File: rtl/w_buf_rd_ctrl.sv
// Streams num_rows consecutive w_buf rows from base_addr, hiding the 1-cycle read
// latency. Optional stall counter output enabled by W_BUF_RD_CTRL_STALL_CNT_EN.
module w_buf_rd_ctrl #(
    parameter int DEPTH      = w_buf_pkg::W_BUF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                clk,
    input  logic                rst_i,
    w_buf_rd_ctrl_if.master     bus
`ifdef W_BUF_RD_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);
    import w_buf_pkg::*;

    rd_state_e             state_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [ADDR_WIDTH-1:0] out_addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic                  done_q;
    logic                  w_valid_q;
    logic                  fire_s;
    logic                  last_s;
    logic                  buf_en_s;
    logic [ADDR_WIDTH-1:0] buf_addr_s;

    assign out_addr_d = ADDR_WIDTH'(wrap(32'(out_addr_q), DEPTH));
    assign fire_s     = w_valid_q & bus.w_ready;
    assign last_s     = (cnt_q == num_q - CNT_WIDTH'(1'b1));

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.w_valid  = w_valid_q;
    assign bus.w_row    = cnt_q;
    assign bus.buf_en   = buf_en_s;
    assign bus.buf_addr = buf_addr_s;

    // Read-port drive: stalls re-read the current row so w_buf dout stays stable.
    always_comb begin
        buf_en_s   = 1'b0;
        buf_addr_s = out_addr_q;
        case (state_q)
            S_IDLE: begin
                buf_en_s   = 1'b0;
                buf_addr_s = out_addr_q;
            end
            S_PRIME: begin
                buf_en_s   = 1'b1;
                buf_addr_s = out_addr_q;
            end
            S_STREAM: begin
                buf_en_s   = !(fire_s && last_s);
                buf_addr_s = fire_s ? out_addr_d : out_addr_q;
            end
            default: begin
                buf_en_s   = 1'b0;
                buf_addr_s = out_addr_q;
            end
        endcase
    end

    // Job FSM with registered done/valid flags and row bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            out_addr_q <= {ADDR_WIDTH{1'b0}};
            cnt_q      <= {CNT_WIDTH{1'b0}};
            num_q      <= {CNT_WIDTH{1'b0}};
            done_q     <= 1'b0;
            w_valid_q  <= 1'b0;
        end else if (bus.abort) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            w_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.num_rows != {CNT_WIDTH{1'b0}}) begin
                            num_q      <= bus.num_rows;
                            out_addr_q <= bus.base_addr;
                            cnt_q      <= {CNT_WIDTH{1'b0}};
                            state_q    <= S_PRIME;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_PRIME: begin
                    state_q   <= S_STREAM;
                    w_valid_q <= 1'b1;
                end
                S_STREAM: begin
                    if (fire_s) begin
                        if (last_s) begin
                            state_q   <= S_IDLE;
                            w_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_q + CNT_WIDTH'(1'b1);
                            out_addr_q <= out_addr_d;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    w_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef W_BUF_RD_CTRL_STALL_CNT_EN
    logic [15:0] stall_q;
    logic        start_acc_s;

    assign start_acc_s = (state_q == S_IDLE) && bus.start && !bus.abort;
    assign stall_cnt   = stall_q;

    // Saturating count of back-pressured valid cycles, cleared per accepted job.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            stall_q <= 16'd0;
        end else if (start_acc_s) begin
            stall_q <= 16'd0;
        end else if (w_valid_q && !bus.w_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end
`endif

endmodule
